// File: rtl/key_debouncer_pkg.sv
// Shared constants for the push-button front end:
// repeat FSM state encodings and 50 MHz default timings.
package key_debouncer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam int DEF_DEBOUNCE_CYC     = 500000;
    localparam int DEF_REPEAT_DELAY_CYC = 25000000;
    localparam int DEF_REPEAT_RATE_CYC  = 5000000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debouncer_channel.sv
// One key: two-flop synchroniser, debounce counter,
// press/release strobes and the auto-repeat FSM.
module debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int ACTIVE_LOW       = 1,
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_EN        = 1,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam logic RELEASED_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int   DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int   HOLD_W =
        $clog2(max2(REPEAT_DELAY_CYC, REPEAT_RATE_CYC) + 1);

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_CYC - 1);

    logic              sync1;
    logic              sync2;
    logic              sync;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        state;
    logic              accept;
    logic              rise;
    logic              fall;

    assign sync   = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    // The cycle that would bring the count to DEBOUNCE_CYC commits the level.
    assign accept = (sync != pressed) && (db_cnt == DB_LAST);
    assign rise   = accept && sync;
    assign fall   = accept && !sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RELEASED_RAW;
            sync2 <= RELEASED_RAW;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt        <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= rise;
            release_pulse <= fall;
            if (sync == pressed || accept)
                db_cnt <= '0;
            else
                db_cnt <= db_cnt + 1'b1;
            if (accept)
                pressed <= sync;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (fall) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
            end else if (rise) begin
                repeat_pulse <= 1'b1;
                hold_cnt     <= '0;
                state        <= (REPEAT_EN != 0) ? ST_DELAY : ST_IDLE;
            end else begin
                unique case (1'b1)
                    (state == ST_DELAY): begin
                        if (hold_cnt == DELAY_LAST) begin
                            repeat_pulse <= 1'b1;
                            hold_cnt     <= '0;
                            state        <= ST_REPEAT;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    (state == ST_REPEAT): begin
                        if (hold_cnt == RATE_LAST) begin
                            repeat_pulse <= 1'b1;
                            hold_cnt     <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Push-button front end: N_KEYS independent debounce channels
// producing clean levels plus press/release/repeat strobes.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int N_KEYS           = 4,
    parameter int ACTIVE_LOW       = 1,
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_EN        = 1,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_raw,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        debounce_channel #(
            .ACTIVE_LOW       (ACTIVE_LOW),
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_EN        (REPEAT_EN),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .key_raw       (keys_raw[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench: window-based reference model feeds a queue,
// a negedge monitor compares two DUTs (repeat on and off).
module tb_key_debouncer;

    localparam int NK   = 4;
    localparam int DB   = 4;
    localparam int DLY  = 20;
    localparam int RATE = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys_raw;
    logic [NK-1:0] pressed_a, press_a, release_a, repeat_a;
    logic [NK-1:0] pressed_b, press_b, release_b, repeat_b;

    always #5 clk = ~clk;

    key_debouncer #(
        .N_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYC(DB), .REPEAT_EN(1),
        .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE)
    ) dut_a (
        .clk(clk), .reset(reset), .keys_raw(keys_raw),
        .pressed(pressed_a), .press_pulse(press_a),
        .release_pulse(release_a), .repeat_pulse(repeat_a)
    );

    key_debouncer #(
        .N_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYC(DB), .REPEAT_EN(0),
        .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE)
    ) dut_b (
        .clk(clk), .reset(reset), .keys_raw(keys_raw),
        .pressed(pressed_b), .press_pulse(press_b),
        .release_pulse(release_b), .repeat_pulse(repeat_b)
    );

    typedef struct packed {
        logic [NK-1:0] pressed;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] rep_a;
        logic [NK-1:0] rep_b;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [NK-1:0] act,
                       input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b expected=%b",
                     name, $time, act, exp);
        end
    endtask

    // Reference: a key's level flips once the last DB synchronised
    // samples (raw seen 2..DB+1 edges ago) all disagree with it.
    logic [63:0]   sh [NK];
    logic [NK-1:0] mp;
    int            t [NK];

    initial begin : model
        exp_t e;
        logic s;
        bit   stable;
        mp = '0;
        for (int k = 0; k < NK; k++) begin
            sh[k] = '0;
            t[k]  = 0;
        end
        forever begin
            @(posedge clk);
            e = '0;
            if (reset) begin
                mp = '0;
                for (int k = 0; k < NK; k++) sh[k] = '0;
            end else begin
                for (int k = 0; k < NK; k++) begin
                    s = ~keys_raw[k];
                    stable = 1'b1;
                    for (int j = 1; j <= DB; j++)
                        if (sh[k][j] == mp[k]) stable = 1'b0;
                    if (stable) begin
                        mp[k] = ~mp[k];
                        if (mp[k]) begin
                            e.press[k] = 1'b1;
                            e.rep_a[k] = 1'b1;
                            t[k] = 0;
                        end else begin
                            e.rel[k] = 1'b1;
                        end
                    end else if (mp[k]) begin
                        t[k]++;
                        if (t[k] == DLY ||
                            (t[k] > DLY && (t[k] - DLY) % RATE == 0))
                            e.rep_a[k] = 1'b1;
                    end
                    sh[k] = {sh[k][62:0], s};
                end
            end
            e.pressed = mp;
            e.rep_b   = e.press;
            q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t g;
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL queue_empty t=%0t actual=0 entries required=1",
                         $time);
            end else begin
                g = q.pop_front();
                chk("pressed_a", pressed_a, g.pressed);
                chk("press_a",   press_a,   g.press);
                chk("release_a", release_a, g.rel);
                chk("repeat_a",  repeat_a,  g.rep_a);
                chk("pressed_b", pressed_b, g.pressed);
                chk("press_b",   press_b,   g.press);
                chk("release_b", release_b, g.rel);
                chk("repeat_b",  repeat_b,  g.rep_b);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : driver
        int left [NK];
        int rst_left;
        reset    = 1'b1;
        keys_raw = '1;
        cyc(3);
        reset = 1'b0;
        cyc(5);
        keys_raw[0] = 1'b0; cyc(12); keys_raw[0] = 1'b1; cyc(10);
        keys_raw[1] = 1'b0; cyc(3);  keys_raw[1] = 1'b1; cyc(10);
        keys_raw[2] = 1'b0; cyc(50); keys_raw[2] = 1'b1; cyc(15);
        keys_raw[0] = 1'b0; keys_raw[3] = 1'b0; cyc(12);
        keys_raw = '1; cyc(10);
        keys_raw[1] = 1'b0; cyc(40);
        reset = 1'b1; cyc(3);
        reset = 1'b0; cyc(15);
        keys_raw[1] = 1'b1; cyc(10);
        keys_raw[0] = 1'b0; cyc(60); keys_raw[0] = 1'b1; cyc(10);

        rst_left = 0;
        for (int k = 0; k < NK; k++) left[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rst_left > 0)
                rst_left--;
            else if ($urandom_range(0, 599) == 0)
                rst_left = $urandom_range(1, 3);
            reset = (rst_left > 0);
            for (int k = 0; k < NK; k++) begin
                if (left[k] == 0) begin
                    keys_raw[k] = ~keys_raw[k];
                    left[k] = ($urandom_range(0, 3) == 0)
                            ? $urandom_range(25, 70)
                            : $urandom_range(1, 8);
                end else begin
                    left[k]--;
                end
            end
            cyc(1);
        end
        reset    = 1'b0;
        keys_raw = '1;
        cyc(12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
